// File: rtl/phase_diff.sv
// phase_diff: turns a stream of scaled-radian phase samples into wrapped
// per-sample phase increments (instantaneous frequency) in a two-stage pipeline.
module phase_diff #(
   parameter int REVERSE_ROTATION = 0,
   parameter int WIDTH_IN         = 16,
   parameter int WIDTH_OUT        = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic [WIDTH_IN-1:0]  i_tdata,
   input  logic                 i_tlast,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [WIDTH_OUT-1:0] o_tdata,
   output logic                 o_tlast,
   output logic                 o_tvalid,
   input  logic                 o_tready
);
   localparam int WD = WIDTH_IN + 1;
   localparam logic signed [WD-1:0] ONE     = WD'(1) << (WIDTH_IN - 3);
   localparam logic signed [WD-1:0] TWO_ONE = WD'(1) << (WIDTH_IN - 2);

   logic                        en;
   logic [WIDTH_IN-1:0]         prev;
   logic signed [WD-1:0]        d_next;
   logic signed [WD-1:0]        s1_d;
   logic                        s1_last;
   logic                        s1_valid;
   logic signed [WD-1:0]        wrap_full;
   logic signed [WIDTH_IN-1:0]  wrapped;
   logic signed [WIDTH_IN-1:0]  rotated;
   logic [WIDTH_OUT-1:0]        result;

   assign en       = o_tready | ~o_tvalid;
   assign i_tready = en;

   // Difference carries one extra bit so the raw step never overflows.
   assign d_next = {i_tdata[WIDTH_IN-1], i_tdata} - {prev[WIDTH_IN-1], prev};

   always_comb begin
      wrap_full = s1_d;
      if (s1_d >= ONE) begin
         wrap_full = s1_d - TWO_ONE;
      end else if (s1_d < -ONE) begin
         wrap_full = s1_d + TWO_ONE;
      end
   end

   assign wrapped = WIDTH_IN'(wrap_full);
   assign rotated = (REVERSE_ROTATION != 0) ? -wrapped : wrapped;

   generate
      if (WIDTH_OUT < WIDTH_IN) begin : g_round
         localparam int SH = WIDTH_IN - WIDTH_OUT;
         logic signed [WD-1:0] rounded;
         // Extra headroom bit keeps round-half-up from overflowing at +max.
         assign rounded = {rotated[WIDTH_IN-1], rotated} + (WD'(1) << (SH - 1));
         assign result  = WIDTH_OUT'(rounded >>> SH);
      end else begin : g_bypass
         assign result = rotated;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev     <= '0;
         s1_d     <= '0;
         s1_last  <= 1'b0;
         s1_valid <= 1'b0;
         o_tdata  <= '0;
         o_tlast  <= 1'b0;
         o_tvalid <= 1'b0;
      end else if (clear) begin
         prev     <= '0;
         s1_valid <= 1'b0;
         o_tvalid <= 1'b0;
      end else if (en) begin
         s1_valid <= i_tvalid;
         o_tvalid <= s1_valid;
         if (i_tvalid) begin
            s1_d    <= d_next;
            s1_last <= i_tlast;
            prev    <= i_tlast ? '0 : i_tdata;
         end
         if (s1_valid) begin
            o_tdata <= result;
            o_tlast <= s1_last;
         end
      end
   end
endmodule

// File: tb/tb_phase_diff.sv
// Bench for phase_diff: three parameterisations share one stimulus stream and
// are scored against an arithmetic reference of the differentiator rules.
module tb_phase_diff;
   localparam int ONE = 8192;

   logic        clk = 1'b0;
   logic        reset_n, clear, i_tvalid, i_tlast, o_tready;
   logic [15:0] i_tdata;
   logic        a_tready, r_tready, n_tready;
   logic [15:0] a_tdata, r_tdata;
   logic [11:0] n_tdata;
   logic        a_tlast, r_tlast, n_tlast;
   logic        a_tvalid, r_tvalid, n_tvalid;

   phase_diff #(.REVERSE_ROTATION(0), .WIDTH_IN(16), .WIDTH_OUT(16)) u_a (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(a_tready),
      .o_tdata(a_tdata), .o_tlast(a_tlast), .o_tvalid(a_tvalid), .o_tready(o_tready));
   phase_diff #(.REVERSE_ROTATION(1), .WIDTH_IN(16), .WIDTH_OUT(16)) u_r (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(r_tready),
      .o_tdata(r_tdata), .o_tlast(r_tlast), .o_tvalid(r_tvalid), .o_tready(o_tready));
   phase_diff #(.REVERSE_ROTATION(0), .WIDTH_IN(16), .WIDTH_OUT(12)) u_n (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(n_tready),
      .o_tdata(n_tdata), .o_tlast(n_tlast), .o_tvalid(n_tvalid), .o_tready(o_tready));

   always #5 clk = ~clk;

   typedef struct {
      int data;
      bit last;
      int cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_r[$];
   exp_t q_n[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   prev_ph = 0;
   int   nco_out = 0;
   int   mon_x;
   int   ph;
   bit   check_lat = 1'b1;
   bit   nco_mode = 1'b0;
   bit   prod_done = 1'b0;
   bit   stall_a = 1'b0;
   int   stall_data = 0;
   bit   stall_last = 1'b0;

   task automatic check(input string tag, input int act, input int exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Reinterpret v as a w-bit two's complement number.
   function automatic int sx(input int v, input int w);
      int m;
      m = v & ((1 << w) - 1);
      if (m >= (1 << (w - 1))) m -= (1 << w);
      return m;
   endfunction

   // Expected increment for variant k: 0 plain, 1 reversed, 2 rounded to 12 bits.
   function automatic int ref_inc(input int x, input int p, input int k);
      int d;
      d = x - p;
      if (d >= ONE) d -= 2 * ONE;
      else if (d < -ONE) d += 2 * ONE;
      d = sx(d, 16);
      if (k == 1) d = sx(-d, 16);
      if (k == 2) d = sx((d + 8) >>> 4, 12);
      return d;
   endfunction

   task automatic take(input int k, input int act, input bit last);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (k)
         0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
         1: if (q_r.size() > 0) begin e = q_r.pop_front(); have = 1'b1; end
         default: if (q_n.size() > 0) begin e = q_n.pop_front(); have = 1'b1; end
      endcase
      check($sformatf("out%0d_expected", k), int'(have), 1);
      if (have) begin
         check($sformatf("out%0d_data", k), act, e.data);
         check($sformatf("out%0d_last", k), int'(last), int'(e.last));
         if (check_lat) check($sformatf("out%0d_latency", k), cyc - e.cyc, 2);
         if (nco_mode && k == 0) begin
            check("nco_inc", act, 37);
            nco_out++;
         end
      end
   endtask

   // Monitor: at each falling edge, decide what the next rising edge transfers.
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         q_a.delete(); q_r.delete(); q_n.delete();
         prev_ph = 0;
         stall_a = 1'b0;
      end else begin
         if (a_tvalid && o_tready) take(0, int'($signed(a_tdata)), a_tlast);
         if (r_tvalid && o_tready) take(1, int'($signed(r_tdata)), r_tlast);
         if (n_tvalid && o_tready) take(2, int'($signed(n_tdata)), n_tlast);
         if (stall_a && a_tvalid) begin
            check("stall_data", int'($signed(a_tdata)), stall_data);
            check("stall_last", int'(a_tlast), int'(stall_last));
         end
         stall_a    = a_tvalid && !o_tready;
         stall_data = int'($signed(a_tdata));
         stall_last = a_tlast;
         if (clear) begin
            q_a.delete(); q_r.delete(); q_n.delete();
            prev_ph = 0;
            stall_a = 1'b0;
         end else if (i_tvalid && a_tready) begin
            mon_x = int'($signed(i_tdata));
            q_a.push_back('{ref_inc(mon_x, prev_ph, 0), i_tlast, cyc});
            q_r.push_back('{ref_inc(mon_x, prev_ph, 1), i_tlast, cyc});
            q_n.push_back('{ref_inc(mon_x, prev_ph, 2), i_tlast, cyc});
            prev_ph = i_tlast ? 0 : mon_x;
         end
      end
   end

   task automatic send(input int x, input bit last);
      bit acc;
      acc = 1'b0;
      i_tdata  = 16'(x);
      i_tlast  = last;
      i_tvalid = 1'b1;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk);
         acc = a_tready && !clear;
         @(posedge clk);
         #1;
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      check("send_accept", int'(acc), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_a.size() + q_r.size() + q_n.size()) != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", q_a.size() + q_r.size() + q_n.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      clear    = 1'b0;
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      i_tdata  = '0;
      o_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", int'(a_tvalid), 0);
      check("rst_data", int'(a_tdata), 0);
      check("rst_last", int'(a_tlast), 0);
      check("rst_ready", int'(a_tready), 1);
      check("rst_valid_n", int'(n_tvalid), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // basic, wrap, packet restart, rounding groups
      send(0, 0); send(100, 0); send(300, 0); send(-200, 1);
      drain();
      send(8000, 0); send(-8000, 1);
      send(-8000, 0); send(8000, 1);
      send(0, 0); send(8192, 1);
      drain();
      send(500, 1); send(700, 0);
      send(724, 0); send(700, 0); send(708, 0); send(715, 1);
      drain();

      // clear with two samples in flight and a concurrent input handshake
      send(10, 0); send(20, 0);
      o_tready = 1'b0;
      clear    = 1'b1;
      i_tvalid = 1'b1;
      i_tdata  = 16'd999;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      check("clear_valid", int'(a_tvalid), 0);
      @(posedge clk);
      #1;
      check("clear_s1_drop", int'(a_tvalid), 0);
      send(50, 1);
      drain();

      // asynchronous reset mid-stream
      send(1000, 0); send(2000, 0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_valid", int'(a_tvalid), 0);
      check("rst_mid_data", int'(a_tdata), 0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      send(3000, 1);
      drain();

      // NCO ramp under random backpressure and random input gaps
      check_lat = 1'b0;
      nco_mode  = 1'b1;
      ph = 0;
      fork
         begin
            for (int k = 0; k < 1000; k++) begin
               ph = ((ph + 37 + ONE) % (2 * ONE)) - ONE;
               repeat ($urandom_range(0, 1)) begin
                  @(posedge clk);
                  #1;
               end
               send(ph, 0);
            end
            prod_done = 1'b1;
         end
         begin
            while (!prod_done) begin
               o_tready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            o_tready = 1'b1;
         end
      join
      drain();
      nco_mode = 1'b0;
      check("nco_count", nco_out, 1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/phase_diff.md
# phase_diff

Phase differentiator: the inverse of the phase accumulator in the DDS/NCO chain. It accepts an AXI-Stream of scaled-radian phase samples and emits the wrapped per-sample phase increment, i.e. instantaneous frequency. It is used on the receive side to recover frequency offset, FM-demodulate, or verify NCO output. Packet boundaries (`i_tlast`) restart the reference phase at zero, mirroring how the accumulator restarts at zero.

## Interface
- `REVERSE_ROTATION`, 0: nonzero negates the output increment.
- `WIDTH_IN`, 16: input phase width, format Q2.(WIDTH_IN-3); 1.0 (= pi) = 2^(WIDTH_IN-3).
- `WIDTH_OUT`, 16: output width, format Q2.(WIDTH_OUT-3); legal range 4 <= WIDTH_OUT <= WIDTH_IN.

- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush, active-high.
- `i_tdata` in WIDTH_IN: signed phase sample.
- `i_tlast` in 1: last sample of packet.
- `i_tvalid` in 1 / `i_tready` out 1: input handshake.
- `o_tdata` out WIDTH_OUT: signed wrapped phase increment.
- `o_tlast` out 1: the input `tlast`, delayed with its sample.
- `o_tvalid` out 1 / `o_tready` in 1: output handshake.

## Operation
- Reference register `prev` (WIDTH_IN, signed) holds the last accepted phase. It is 0 after reset, after clear, and after any accepted beat with `i_tlast`=1.
- Stage 1 (on input accept):
  - d = sext(i_tdata) - sext(prev), computed in WIDTH_IN+1 bits.
  - Register d and tlast.
  - `prev` <= i_tdata, or <= 0 if i_tlast.
- Stage 2 wrap, with ONE = 2^(WIDTH_IN-3), exactly one correction:
  - d >= ONE: d - 2*ONE.
  - d < -ONE: d + 2*ONE.
  - Otherwise d unchanged.
  - For legal inputs in [-ONE, +ONE], the result is in [-ONE, +ONE).
  - Out-of-range inputs still get a single correction, then the low WIDTH_IN bits are kept. No saturation.
- Stage 2 negate: if REVERSE_ROTATION, negate the wrapped value. -(-ONE) = +ONE and is representable.
- Stage 2 round: if WIDTH_OUT < WIDTH_IN, add 2^(WIDTH_IN-WIDTH_OUT-1), then arithmetic-shift right by WIDTH_IN-WIDTH_OUT (round half up). If the widths are equal, bypass.
- Register the stage 2 result into `o_tdata` and `o_tlast`.
- No state machine. Two-stage valid pipeline (`s1_valid`, `o_tvalid`) under a global enable en = o_tready | ~o_tvalid.

## Timing
- Reset values: `o_tdata`=0, `o_tlast`=0, `o_tvalid`=0, `s1_valid`=0, `prev`=0.
- `i_tready` = en, combinational from `o_tready` and `o_tvalid`. It is high out of reset.
- Latency: a sample accepted on cycle N appears on the output at cycle N+2 when not stalled. Sustained throughput is 1 sample/clock with `o_tready`=1.
- Stall (`o_tready`=0 with `o_tvalid`=1): all pipeline registers and `prev` hold. `o_tdata`/`o_tlast` stay stable until accepted. No data is lost or duplicated.
- An empty stage advances when en=1. Bubbles propagate; they are not collapsed.
- `clear`, registered on the clock edge:
  - Zeroes `prev`, `s1_valid` and `o_tvalid`.
  - Drops in-flight data.
  - Any input handshake in the same cycle is discarded.
  - `clear` has priority over all other updates.
- `reset_n` deassertion mid-stream: the pipeline is empty and the next accepted sample is differenced against 0.
- tlast beat: its own output is i_tdata - prev_old (normal). The following sample is differenced against 0.

## Test plan
(WIDTH_IN=WIDTH_OUT=16, ONE=8192 unless noted.)
- Basic: inputs 0, 100, 300, -200 with o_tready=1 -> outputs 0, 100, 200, -500. First output appears 2 cycles after first accept.
- Wrap:
  - Inputs 8000, -8000 -> outputs 8000, 384.
  - Inputs -8000, 8000 -> outputs -8000, -384.
  - Inputs 0, 8192 -> outputs 0, -8192.
- Packet restart: inputs 500 (tlast=1), 700 -> outputs 500 with o_tlast=1, then 700 with o_tlast=0.
- Backpressure:
  - Random o_tready (50%) and random i_tvalid over 1000 NCO-generated samples with constant increment 37, wrapping through ±ONE.
  - Every output is 37, counts match, o_tdata stable while stalled.
- Reverse and rounding:
  - REVERSE_ROTATION=1: inputs 0, 100 -> 0, -100.
  - WIDTH_OUT=12: increments 24 -> 2, -24 -> -1, 8 -> 1, 7 -> 0.
- Clear and reset:
  - Assert clear with two samples in flight -> o_tvalid=0 next cycle; the next input 50 outputs 50.
  - Pulse reset_n low asynchronously mid-stream -> outputs go to 0/invalid immediately.
